// File: rtl/prog_ctr.sv
// Program counter for the custom-ISA core: idles after reset, launches to the
// next program base when Start falls, then increments or takes absolute branches.
module prog_ctr #(
  parameter int PC_W       = 10,
  parameter int NUM_PROGS  = 3,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 256,
  parameter int PROG2_BASE = 512,
  parameter int PROG3_BASE = 768
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchAbsEn,
  input  logic            ALU_flag,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      prog_idx_q, prog_idx_d;
  logic [PC_W-1:0] base_addr;

  always_comb begin
    case (prog_idx_q)
      2'd0:    base_addr = PC_W'(PROG0_BASE);
      2'd1:    base_addr = PC_W'(PROG1_BASE);
      2'd2:    base_addr = PC_W'(PROG2_BASE);
      default: base_addr = PC_W'(PROG3_BASE);
    endcase
  end

  // Launch happens on the first edge where Start is sampled low after ARMED.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_idx_d = prog_idx_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = ARMED;
      end
      ARMED: begin
        if (!Start) begin
          pc_d       = base_addr;
          prog_idx_d = (prog_idx_q >= LAST_IDX) ? 2'd0 : prog_idx_q + 2'd1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (Start)                        state_d = ARMED;
        else if (BranchAbsEn && ALU_flag) pc_d    = Target;
        else                              pc_d    = pc_q + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      prog_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_idx_q <= prog_idx_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: hand-computed PC and state after each edge.
module tb_prog_ctr;

  localparam int PC_W = 10;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Start = 1'b0;
  logic            BranchAbsEn = 1'b0;
  logic            ALU_flag = 1'b0;
  logic [PC_W-1:0] Target = '0;
  logic [PC_W-1:0] ProgCtr;
  logic [1:0]      state_dbg;

  int vectors = 0;
  int miscompares = 0;

  prog_ctr dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .BranchAbsEn(BranchAbsEn),
    .ALU_flag(ALU_flag),
    .Target(Target),
    .ProgCtr(ProgCtr),
    .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [PC_W-1:0] exp);
    vectors++;
    assert (ProgCtr === exp) else begin
      miscompares++;
      $error("FAIL %s: ProgCtr observed %0d expected %0d", tag, ProgCtr, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] exp);
    vectors++;
    assert (state_dbg === exp) else begin
      miscompares++;
      $error("FAIL %s: state observed %0d expected %0d", tag, state_dbg, exp);
    end
  endtask

  initial begin
    #1;
    Reset = 1'b1; step();
    check_pc("reset_pc", 10'd0); check_st("reset_st", S_IDLE);

    Reset = 1'b0; Start = 1'b0; step();
    check_pc("idle_hold", 10'd0); check_st("idle_st", S_IDLE);

    BranchAbsEn = 1'b1; ALU_flag = 1'b1; Target = 10'd77; step();
    check_pc("idle_ignores_branch", 10'd0);
    BranchAbsEn = 1'b0; ALU_flag = 1'b0;

    Start = 1'b1; step();
    check_pc("armed_hold", 10'd0); check_st("armed_st", S_ARMED);
    Start = 1'b0; step();
    check_pc("launch_prog0", 10'd0); check_st("run_st", S_RUN);
    step();
    check_pc("incr_1", 10'd1);

    BranchAbsEn = 1'b1; ALU_flag = 1'b1; Target = 10'd10; step();
    check_pc("branch_10", 10'd10);
    BranchAbsEn = 1'b0; step();
    check_pc("incr_11", 10'd11);

    BranchAbsEn = 1'b1; ALU_flag = 1'b0; Target = 10'd5; step();
    check_pc("flag0_no_branch", 10'd12);

    ALU_flag = 1'b1; Target = 10'd1023; step();
    check_pc("branch_1023", 10'd1023);
    BranchAbsEn = 1'b0; ALU_flag = 1'b0; step();
    check_pc("wrap_0", 10'd0);

    Start = 1'b1;
    BranchAbsEn = 1'b1; ALU_flag = 1'b1; Target = 10'd99; step();
    check_pc("start_beats_branch", 10'd0); check_st("rearm_st", S_ARMED);
    BranchAbsEn = 1'b0; ALU_flag = 1'b0; step();
    check_pc("start_held", 10'd0);
    Start = 1'b0; step();
    check_pc("launch_prog1", 10'd256);
    step();
    check_pc("incr_257", 10'd257);

    Start = 1'b1; step();
    check_pc("hold_257", 10'd257);
    Start = 1'b0; step();
    check_pc("launch_prog2", 10'd512);

    Start = 1'b1; step();
    Start = 1'b0; step();
    check_pc("launch_wrap_prog0", 10'd0);
    step();
    check_pc("incr_after_wrap", 10'd1);

    BranchAbsEn = 1'b1; ALU_flag = 1'b1; Target = 10'd300; step();
    check_pc("branch_300", 10'd300);
    BranchAbsEn = 1'b0; ALU_flag = 1'b0;

    Reset = 1'b1; Start = 1'b1; step();
    check_pc("midrun_reset_pc", 10'd0); check_st("midrun_reset_st", S_IDLE);
    Reset = 1'b0; Start = 1'b0; step();
    check_pc("post_reset_idle", 10'd0); check_st("post_reset_st", S_IDLE);

    Start = 1'b1; step();
    Start = 1'b0; step();
    check_pc("relaunch_prog0", 10'd0); check_st("relaunch_st", S_RUN);
    step();
    check_pc("relaunch_incr", 10'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
